// File: rtl/uart_pkg.sv
// Shared constants for the UART command engine: parity modes,
// FSM state encodings and read_err bit positions.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_TMO = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_BYTE = 3'd1,
        TX_GAP  = 3'd2,
        RX_WAIT = 3'd3,
        RX_BYTE = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/uart_cmd_engine_if.sv
// Command handshake plus serial lines and read-response bundle
// of the UART command engine.
interface uart_cmd_engine_if #(
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8
);
    logic [CMD_WIDTH-1:0]  cmd_in;
    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic                  rx;
    logic                  tx;
    logic                  read_vld;
    logic [READ_WIDTH-1:0] read_data;
    logic [2:0]            read_err;

    modport master (
        output cmd_in, cmd_vld, rx,
        input  cmd_rdy, tx, read_vld, read_data, read_err
    );

    modport slave (
        input  cmd_in, cmd_vld, rx,
        output cmd_rdy, tx, read_vld, read_data, read_err
    );
endinterface

// File: rtl/uart_rx_byte.sv
// Receive one UART character: 2-flop sync, start validation at
// half-bit, centre sampling, parity and stop checks.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int DIV       = 434,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    input  logic       i_en,
    output logic       o_busy,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_par_err,
    output logic       o_frm_err
);
    localparam int NB = 9 + ((PARITY != PAR_NONE) ? 1 : 0) + STOP_BITS;
    localparam int CW = $clog2(DIV);

    logic          r_s1, r_s2, r_s3;
    logic          r_act;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_idx;
    logic [7:0]    r_sh;
    logic          w_fall;

    assign w_fall = r_s3 & ~r_s2;
    assign o_busy = r_act;
    assign o_byte = r_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_s3       <= 1'b1;
            r_act      <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_sh       <= '0;
            o_byte_vld <= 1'b0;
            o_par_err  <= 1'b0;
            o_frm_err  <= 1'b0;
        end else begin
            r_s1       <= i_rx;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            o_byte_vld <= 1'b0;
            if (!i_en) begin
                r_act <= 1'b0;
            end else if (!r_act) begin
                if (w_fall) begin
                    r_act     <= 1'b1;
                    r_cnt     <= CW'(DIV/2 - 1);
                    r_idx     <= '0;
                    o_par_err <= 1'b0;
                    o_frm_err <= 1'b0;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                // reload from the sample point itself, so no drift accumulates
                r_cnt <= CW'(DIV - 1);
                r_idx <= r_idx + 4'd1;
                if (r_idx == 4'd0) begin
                    if (r_s2) r_act <= 1'b0;
                end else if (r_idx <= 4'd8) begin
                    r_sh <= {r_s2, r_sh[7:1]};
                end else if (PARITY != PAR_NONE && r_idx == 4'd9) begin
                    o_par_err <= (^{r_sh, r_s2}) != (PARITY == PAR_ODD);
                end else begin
                    if (!r_s2) o_frm_err <= 1'b1;
                    if (r_idx == 4'(NB - 1)) begin
                        r_act      <= 1'b0;
                        o_byte_vld <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/uart_cmd_engine.sv
// Sends a command over UART MSB byte first; read commands then
// collect a framed response with inter-byte timeout.
module uart_cmd_engine
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int CMD_WIDTH    = 16,
    parameter int READ_WIDTH   = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int TIMEOUT_BITS = 40
) (
    input logic               clk,
    input logic               rst_n,
    uart_cmd_engine_if.slave  bus
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int NBITS = 9 + ((PARITY != PAR_NONE) ? 1 : 0) + STOP_BITS;
    localparam int NCB   = CMD_WIDTH / 8;
    localparam int NRB   = READ_WIDTH / 8;
    localparam int TMO   = TIMEOUT_BITS * DIV;
    localparam int CW    = $clog2(DIV);
    localparam int TW    = $clog2(TMO);

    state_t                r_state;
    logic [CMD_WIDTH-1:0]  r_cmd;
    logic                  r_is_rd;
    logic [3:0]            r_tx_left;
    logic [11:0]           r_shift;
    logic [3:0]            r_bit;
    logic [CW-1:0]         r_baud;
    logic [TW-1:0]         r_tmo;
    logic [3:0]            r_rx_cnt;
    logic [READ_WIDTH-1:0] r_acc;
    logic [2:0]            r_err;
    logic                  r_tx, r_cmd_rdy, r_read_vld;
    logic [READ_WIDTH-1:0] r_read_data;
    logic [2:0]            r_read_err;

    logic                  w_rx_en, w_busy, w_bvld, w_perr, w_ferr;
    logic [7:0]            w_byte;
    logic [5:0]            w_lsb;
    logic [READ_WIDTH-1:0] w_acc_nxt;
    logic [2:0]            w_err_nxt;

    assign bus.tx        = r_tx;
    assign bus.cmd_rdy   = r_cmd_rdy;
    assign bus.read_vld  = r_read_vld;
    assign bus.read_data = r_read_data;
    assign bus.read_err  = r_read_err;
    assign w_rx_en       = (r_state == RX_WAIT) || (r_state == RX_BYTE);

    // {stop..., parity, data, start}; unused upper bits stay 1
    function automatic logic [11:0] frame(input logic [7:0] d);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (PARITY == PAR_ODD)  f[9] = ~^d;
        if (PARITY == PAR_EVEN) f[9] = ^d;
        return f;
    endfunction

    always_comb begin
        w_lsb                 = 6'((NRB - 1 - int'(r_rx_cnt)) * 8);
        w_acc_nxt             = r_acc;
        w_acc_nxt[w_lsb +: 8] = w_byte;
        w_err_nxt             = r_err;
        w_err_nxt[ERR_PAR]    = r_err[ERR_PAR] | w_perr;
        w_err_nxt[ERR_FRM]    = r_err[ERR_FRM] | w_ferr;
    end

    uart_rx_byte #(
        .DIV       (DIV),
        .PARITY    (PARITY),
        .STOP_BITS (STOP_BITS)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx       (bus.rx),
        .i_en       (w_rx_en),
        .o_busy     (w_busy),
        .o_byte     (w_byte),
        .o_byte_vld (w_bvld),
        .o_par_err  (w_perr),
        .o_frm_err  (w_ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_is_rd     <= 1'b0;
            r_tx_left   <= '0;
            r_shift     <= '0;
            r_bit       <= '0;
            r_baud      <= '0;
            r_tmo       <= '0;
            r_rx_cnt    <= '0;
            r_acc       <= '0;
            r_err       <= '0;
            r_tx        <= 1'b1;
            r_cmd_rdy   <= 1'b1;
            r_read_vld  <= 1'b0;
            r_read_data <= '0;
            r_read_err  <= '0;
        end else begin
            r_read_vld <= 1'b0;
            unique case (r_state)
                IDLE: if (bus.cmd_vld) begin
                    r_cmd     <= bus.cmd_in << 8;
                    r_is_rd   <= bus.cmd_in[CMD_WIDTH-1];
                    r_tx_left <= 4'(NCB - 1);
                    r_shift   <= frame(bus.cmd_in[CMD_WIDTH-1 -: 8]) >> 1;
                    r_tx      <= 1'b0;
                    r_bit     <= 4'(NBITS - 1);
                    r_baud    <= CW'(DIV - 1);
                    r_rx_cnt  <= '0;
                    r_acc     <= '0;
                    r_err     <= '0;
                    r_cmd_rdy <= 1'b0;
                    r_state   <= TX_BYTE;
                end
                TX_BYTE: if (r_baud != '0) begin
                    r_baud <= r_baud - 1'b1;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit - 4'd1;
                    r_baud  <= CW'(DIV - 1);
                    if (r_bit == 4'd1) r_state <= TX_GAP;
                end
                // TX_GAP spans the final stop bit, so the next start follows directly
                TX_GAP: if (r_baud != '0) begin
                    r_baud <= r_baud - 1'b1;
                end else if (r_tx_left != '0) begin
                    r_cmd     <= r_cmd << 8;
                    r_tx_left <= r_tx_left - 4'd1;
                    r_shift   <= frame(r_cmd[CMD_WIDTH-1 -: 8]) >> 1;
                    r_tx      <= 1'b0;
                    r_bit     <= 4'(NBITS - 1);
                    r_baud    <= CW'(DIV - 1);
                    r_state   <= TX_BYTE;
                end else if (r_is_rd) begin
                    r_tmo   <= TW'(TMO - 1);
                    r_state <= RX_WAIT;
                end else begin
                    r_state <= DONE;
                end
                RX_WAIT: if (w_busy) begin
                    r_state <= RX_BYTE;
                end else if (r_tmo == '0) begin
                    r_read_vld  <= 1'b1;
                    r_read_data <= r_acc;
                    r_read_err  <= r_err | 3'(1 << ERR_TMO);
                    r_state     <= DONE;
                end else begin
                    r_tmo <= r_tmo - 1'b1;
                end
                RX_BYTE: if (w_bvld) begin
                    r_acc    <= w_acc_nxt;
                    r_err    <= w_err_nxt;
                    r_rx_cnt <= r_rx_cnt + 4'd1;
                    if (r_rx_cnt == 4'(NRB - 1)) begin
                        r_read_vld  <= 1'b1;
                        r_read_data <= w_acc_nxt;
                        r_read_err  <= w_err_nxt;
                        r_state     <= DONE;
                    end else begin
                        r_tmo   <= TW'(TMO - 1);
                        r_state <= RX_WAIT;
                    end
                end else if (!w_busy) begin
                    r_tmo   <= TW'(TMO - 1);
                    r_state <= RX_WAIT;
                end
                DONE: begin
                    r_cmd_rdy <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_cmd_engine.md
UART_CMD_ENGINE -- requirements
Module: uart_cmd_engine

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency.
REQ-002 SHALL have parameter BAUD, default 115200, line rate; DIV = CLK_HZ/BAUD (integer, truncated), DIV >= 16.
REQ-003 SHALL have parameter CMD_WIDTH, default 16, command width, multiple of 8, 8..64.
REQ-004 SHALL have parameter READ_WIDTH, default 8, read-response width, multiple of 8, 8..64.
REQ-005 SHALL have parameter PARITY, default 1, 0 = none, 1 = odd, 2 = even.
REQ-006 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-007 SHALL have parameter TIMEOUT_BITS, default 40, bit-times allowed between read-response bytes.
REQ-008 SHALL have port clk, input, 1, clock.
REQ-009 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-010 SHALL have port cmd_in, input, CMD_WIDTH, command; MSB = 1 means read, MSB = 0 means write.
REQ-011 SHALL have port cmd_vld, input, 1, command valid.
REQ-012 SHALL have port cmd_rdy, output, 1, engine idle and accepting a command.
REQ-013 SHALL have port rx, input, 1, asynchronous serial input.
REQ-014 SHALL have port tx, output, 1, serial output; idles high.
REQ-015 SHALL have port read_vld, output, 1, one-cycle pulse, read complete.
REQ-016 SHALL have port read_data, output, READ_WIDTH, read response, first byte received in the MSBs.
REQ-017 SHALL have port read_err, output, 3, {timeout, framing, parity}, valid with read_vld.

Function
REQ-018 SHALL accept a command on the cycle where cmd_vld && cmd_rdy, capture cmd_in, and deassert cmd_rdy on the next cycle.
REQ-019 SHALL ignore cmd_vld while cmd_rdy = 0; cmd_in need not be held after acceptance.
REQ-020 SHALL implement FSM states IDLE, TX_BYTE, TX_GAP, RX_WAIT, RX_BYTE and DONE.
REQ-021 SHALL send CMD_WIDTH/8 bytes, MSB byte first.
REQ-022 SHALL frame each byte as: start (0), 8 data bits LSB first, a parity bit (only if PARITY != 0), then STOP_BITS stop bits (1), each DIV clocks.
REQ-023 SHALL compute the parity bit so that data plus parity has odd (PARITY = 1) or even (PARITY = 2) weight.
REQ-024 SHALL insert no idle time between bytes; TX_GAP lasts 0 cycles beyond the stop bit(s).
REQ-025 SHALL, for a write command, go to DONE after the last stop bit, then to IDLE one cycle later with cmd_rdy = 1; no read_vld pulse SHALL be generated.
REQ-026 SHALL, for a read command, enter RX_WAIT after the last stop bit and start the timeout counter.
REQ-027 SHALL synchronise rx with a 2-flop synchroniser and detect the start bit on a 1-to-0 edge of the synchronised signal.
REQ-028 SHALL resample the start bit at DIV/2; if it is high, discard it as a glitch and stay in RX_WAIT.
REQ-029 SHALL sample each subsequent bit at its centre (DIV/2 + k*DIV after the edge).
REQ-030 SHALL set the parity error bit on a parity mismatch and the framing error bit on any stop bit sampled low; both errors SHALL be sticky per command.
REQ-031 SHALL end the read with timeout = 1, read_data = bytes received so far (remaining bytes 0), and a read_vld pulse if no start edge arrives within TIMEOUT_BITS*DIV clocks of entering RX_WAIT.
REQ-032 SHALL shift each received byte into read_data and, after READ_WIDTH/8 bytes, pulse read_vld for 1 cycle in DONE, with cmd_rdy = 1 on the following cycle.
REQ-033 SHALL hold read_data stable until the next read completes.
REQ-034 SHALL ignore rx activity in IDLE and in TX states; it is not buffered.
REQ-035 SHALL reload the baud counter on each bit boundary with no cumulative drift; bit period is exactly DIV clocks.

Reset
REQ-036 SHALL, on rst_n low, put the FSM in IDLE and drive tx = 1, cmd_rdy = 1, read_vld = 0, read_data = 0, read_err = 0, with all counters at 0.
REQ-037 SHALL, on reset mid-frame, force tx high immediately (asynchronously) and discard the command without a read_vld pulse.

Structure
REQ-038 SHALL place the parity-mode constants, FSM state encodings and read_err bit indices in shared package uart_pkg.
REQ-039 SHALL implement the receive path (synchroniser, start validation, bit sampling, parity/stop check) as sub-module uart_rx_byte, outputting byte, byte_vld, par_err and frm_err.

Verification
REQ-040 SHALL cover: write 16'h1234, PARITY = 1, DIV = 434 -> tx bytes 0x12 then 0x34, parity bits 1 and 0, 2*11*434 clocks, cmd_rdy high 1 cycle after DONE, no read_vld.
REQ-041 SHALL cover: read 16'h8005, model replies 0xA5 with correct parity -> read_vld once, read_data = 8'hA5, read_err = 3'b000.
REQ-042 SHALL cover: read with reply 0x3C carrying a wrong parity bit -> read_data = 8'h3C, read_err = 3'b001.
REQ-043 SHALL cover: read with no reply -> read_vld exactly 40*DIV clocks after RX_WAIT entry, read_err = 3'b100, read_data = 0.
REQ-044 SHALL cover: a rx glitch low for DIV/4 in RX_WAIT followed by a valid byte -> only the valid byte is captured; also cmd_vld during busy -> ignored, and rst_n pulsed mid-byte -> tx = 1 and cmd_rdy = 1 on reset.
